robo_odometria: RTL and testbench

- Synthesizable pose and debris tracker that sits directly downstream of the `Robo` controller.
- Consumes its `avancar`, `girar` and `recolher_entulho` commands and maintains the robot's row, column, heading and remaining debris life.
- Flags illegal moves, which previously could only be caught in simulation.
- Its outputs feed the map/sensor logic that generates `head`, `left`, `under` and `barrier`.

---
 rtl/robo_pkg.sv | 74 +++++++
 rtl/robo_entulho_timer.sv | 54 +++++
 rtl/robo_odometria.sv | 169 ++++++++++++++++
 tb/tb_robo_odometria.sv | 243 ++++++++++++++++++++++++
 4 files changed

// File: rtl/robo_pkg.sv
// Shared types and helpers for the Robo odometry slice: headings, map codes,
// tracker states, default debris lives and pose helper functions.
package robo_pkg;

  typedef enum logic [1:0] {
    ORI_N = 2'b00,
    ORI_S = 2'b01,
    ORI_L = 2'b10,
    ORI_O = 2'b11
  } orient_t;

  typedef enum logic [2:0] {
    LIVRE  = 3'd0,
    PAREDE = 3'd1,
    PRETA  = 3'd2,
    LEVE   = 3'd3,
    MEDIO  = 3'd4,
    PESADO = 3'd5
  } mapa_t;

  typedef enum logic [1:0] {
    PARADO,
    ATIVO,
    REMOVENDO,
    ANOMALIA
  } estado_t;

  typedef struct packed {
    logic [3:0] linha;
    logic [4:0] coluna;
  } celula_t;

  localparam int unsigned VIDA_LEVE_DEF   = 3;
  localparam int unsigned VIDA_MEDIO_DEF  = 6;
  localparam int unsigned VIDA_PESADO_DEF = 9;

  function automatic orient_t girar_esq(input orient_t o);
    unique case (o)
      ORI_N:   return ORI_O;
      ORI_O:   return ORI_S;
      ORI_S:   return ORI_L;
      default: return ORI_N;
    endcase
  endfunction

  // Zero means the code is not removable debris.
  function automatic logic [3:0] vida_total(input logic [2:0] tipo,
                                            input int unsigned leve,
                                            input int unsigned medio,
                                            input int unsigned pesado);
    case (tipo)
      LEVE:    return 4'(leve);
      MEDIO:   return 4'(medio);
      PESADO:  return 4'(pesado);
      default: return '0;
    endcase
  endfunction

  function automatic celula_t celula_frente(input logic [3:0] linha,
                                            input logic [4:0] coluna,
                                            input orient_t o);
    celula_t c;
    c.linha  = linha;
    c.coluna = coluna;
    unique case (o)
      ORI_N:   c.linha  = linha - 4'd1;
      ORI_S:   c.linha  = linha + 4'd1;
      ORI_L:   c.coluna = coluna + 5'd1;
      default: c.coluna = coluna - 5'd1;
    endcase
    return c;
  endfunction

endpackage

// File: rtl/robo_entulho_timer.sv
// Debris life countdown: loads the remaining removal cycles for a debris type
// and pulses when the count reaches zero.
module robo_entulho_timer
  import robo_pkg::*;
#(
  parameter int unsigned VIDA_LEVE   = VIDA_LEVE_DEF,
  parameter int unsigned VIDA_MEDIO  = VIDA_MEDIO_DEF,
  parameter int unsigned VIDA_PESADO = VIDA_PESADO_DEF
) (
  input  logic       clock,
  input  logic       reset,
  input  logic       limpar,
  input  logic       carregar,
  input  logic [2:0] tipo,
  input  logic       decrementar,
  output logic [3:0] vida,
  output logic       concluido
);

  logic [3:0] vida_q, vida_d;
  logic       concl_q, concl_d;
  logic [3:0] total;

  assign total = vida_total(tipo, VIDA_LEVE, VIDA_MEDIO, VIDA_PESADO);

  // The loading cycle already counts as one removal cycle.
  always_comb begin
    vida_d  = vida_q;
    concl_d = 1'b0;
    if (limpar) begin
      vida_d = '0;
    end else if (carregar && total != '0) begin
      vida_d  = total - 4'd1;
      concl_d = (total == 4'd1);
    end else if (decrementar && vida_q != '0) begin
      vida_d  = vida_q - 4'd1;
      concl_d = (vida_q == 4'd1);
    end
  end

  always_ff @(posedge clock) begin
    if (reset) begin
      vida_q  <= '0;
      concl_q <= 1'b0;
    end else begin
      vida_q  <= vida_d;
      concl_q <= concl_d;
    end
  end

  assign vida      = vida_q;
  assign concluido = concl_q;

endmodule

// File: rtl/robo_odometria.sv
// Pose and debris tracker downstream of the Robo controller: follows the
// movement/removal commands and flags moves that would leave the map.
module robo_odometria
  import robo_pkg::*;
#(
  parameter int unsigned LINHAS      = 10,
  parameter int unsigned COLUNAS     = 20,
  parameter int unsigned VIDA_LEVE   = VIDA_LEVE_DEF,
  parameter int unsigned VIDA_MEDIO  = VIDA_MEDIO_DEF,
  parameter int unsigned VIDA_PESADO = VIDA_PESADO_DEF
) (
  input  logic       clock,
  input  logic       reset,
  input  logic       carregar,
  input  logic [3:0] linha_ini,
  input  logic [4:0] coluna_ini,
  input  logic [1:0] orient_ini,
  input  logic       avancar,
  input  logic       girar,
  input  logic       recolher_entulho,
  input  logic [2:0] tipo_entulho,
  output logic [3:0] linha,
  output logic [4:0] coluna,
  output logic [1:0] orientacao,
  output logic [3:0] entulho_vida,
  output logic       entulho_removido,
  output logic [3:0] remov_linha,
  output logic [4:0] remov_coluna,
  output logic       anomalia
);

  localparam logic [4:0] LINHAS_W = 5'(LINHAS);
  localparam logic [5:0] COLUNAS_W = 6'(COLUNAS);
  localparam logic [3:0] LIN_MAX  = 4'(LINHAS - 1);
  localparam logic [4:0] COL_MAX  = 5'(COLUNAS - 1);

  estado_t    estado_q, estado_d;
  logic [3:0] linha_q, linha_d;
  logic [4:0] coluna_q, coluna_d;
  orient_t    orient_q, orient_d;
  logic       anomalia_q, anomalia_d;
  logic [3:0] remov_linha_q, remov_linha_d;
  logic [4:0] remov_coluna_q, remov_coluna_d;

  logic       carga_invalida, borda, eh_entulho;
  logic       t_limpar, t_carregar, t_dec;
  logic [3:0] vida_carga;
  celula_t    frente;

  assign carga_invalida = ({1'b0, linha_ini} >= LINHAS_W) ||
                          ({1'b0, coluna_ini} >= COLUNAS_W);
  assign vida_carga     = vida_total(tipo_entulho, VIDA_LEVE, VIDA_MEDIO, VIDA_PESADO);
  assign eh_entulho     = (vida_carga != '0);
  assign frente         = celula_frente(linha_q, coluna_q, orient_q);

  always_comb begin
    unique case (orient_q)
      ORI_N:   borda = (linha_q == '0);
      ORI_S:   borda = (linha_q == LIN_MAX);
      ORI_L:   borda = (coluna_q == COL_MAX);
      default: borda = (coluna_q == '0);
    endcase
  end

  always_comb begin
    estado_d       = estado_q;
    linha_d        = linha_q;
    coluna_d       = coluna_q;
    orient_d       = orient_q;
    anomalia_d     = anomalia_q;
    remov_linha_d  = remov_linha_q;
    remov_coluna_d = remov_coluna_q;
    t_limpar       = 1'b0;
    t_carregar     = 1'b0;
    t_dec          = 1'b0;
    if (estado_q != ANOMALIA && carregar) begin
      if (carga_invalida) begin
        estado_d   = ANOMALIA;
        anomalia_d = 1'b1;
      end else begin
        estado_d = ATIVO;
        linha_d  = linha_ini;
        coluna_d = coluna_ini;
        orient_d = orient_t'(orient_ini);
        t_limpar = 1'b1;
      end
    end else begin
      unique case (estado_q)
        ATIVO: begin
          if (recolher_entulho) begin
            if (eh_entulho) begin
              t_carregar = 1'b1;
              if (vida_carga == 4'd1) begin
                remov_linha_d  = frente.linha;
                remov_coluna_d = frente.coluna;
              end else begin
                estado_d = REMOVENDO;
              end
            end
          end else if (avancar) begin
            if (borda) begin
              estado_d   = ANOMALIA;
              anomalia_d = 1'b1;
            end else begin
              linha_d  = frente.linha;
              coluna_d = frente.coluna;
            end
          end else if (girar) begin
            orient_d = girar_esq(orient_q);
          end
        end
        REMOVENDO: begin
          if (recolher_entulho) begin
            t_dec = 1'b1;
            if (entulho_vida == 4'd1) begin
              estado_d       = ATIVO;
              remov_linha_d  = frente.linha;
              remov_coluna_d = frente.coluna;
            end
          end
        end
        default: ;
      endcase
    end
  end

  always_ff @(posedge clock) begin
    if (reset) begin
      estado_q       <= PARADO;
      linha_q        <= '0;
      coluna_q       <= '0;
      orient_q       <= ORI_N;
      anomalia_q     <= 1'b0;
      remov_linha_q  <= '0;
      remov_coluna_q <= '0;
    end else begin
      estado_q       <= estado_d;
      linha_q        <= linha_d;
      coluna_q       <= coluna_d;
      orient_q       <= orient_d;
      anomalia_q     <= anomalia_d;
      remov_linha_q  <= remov_linha_d;
      remov_coluna_q <= remov_coluna_d;
    end
  end

  robo_entulho_timer #(
    .VIDA_LEVE  (VIDA_LEVE),
    .VIDA_MEDIO (VIDA_MEDIO),
    .VIDA_PESADO(VIDA_PESADO)
  ) u_timer (
    .clock      (clock),
    .reset      (reset),
    .limpar     (t_limpar),
    .carregar   (t_carregar),
    .tipo       (tipo_entulho),
    .decrementar(t_dec),
    .vida       (entulho_vida),
    .concluido  (entulho_removido)
  );

  assign linha        = linha_q;
  assign coluna       = coluna_q;
  assign orientacao   = orient_q;
  assign remov_linha  = remov_linha_q;
  assign remov_coluna = remov_coluna_q;
  assign anomalia     = anomalia_q;

endmodule

// File: tb/tb_robo_odometria.sv
// Directed bench for robo_odometria: a behavioural pose model checked every
// cycle plus literal expectations at the key points of each scenario.
module tb_robo_odometria;

  logic       clock = 1'b0;
  logic       reset = 1'b0;
  logic       carregar = 1'b0;
  logic [3:0] linha_ini = '0;
  logic [4:0] coluna_ini = '0;
  logic [1:0] orient_ini = '0;
  logic       avancar = 1'b0;
  logic       girar = 1'b0;
  logic       recolher_entulho = 1'b0;
  logic [2:0] tipo_entulho = '0;
  logic [3:0] linha;
  logic [4:0] coluna;
  logic [1:0] orientacao;
  logic [3:0] entulho_vida;
  logic       entulho_removido;
  logic [3:0] remov_linha;
  logic [4:0] remov_coluna;
  logic       anomalia;

  int checks = 0;
  int errors = 0;

  robo_odometria #(
    .LINHAS     (10),
    .COLUNAS    (20),
    .VIDA_LEVE  (3),
    .VIDA_MEDIO (6),
    .VIDA_PESADO(9)
  ) dut (
    .clock           (clock),
    .reset           (reset),
    .carregar        (carregar),
    .linha_ini       (linha_ini),
    .coluna_ini      (coluna_ini),
    .orient_ini      (orient_ini),
    .avancar         (avancar),
    .girar           (girar),
    .recolher_entulho(recolher_entulho),
    .tipo_entulho    (tipo_entulho),
    .linha           (linha),
    .coluna          (coluna),
    .orientacao      (orientacao),
    .entulho_vida    (entulho_vida),
    .entulho_removido(entulho_removido),
    .remov_linha     (remov_linha),
    .remov_coluna    (remov_coluna),
    .anomalia        (anomalia)
  );

  always #5 clock = ~clock;

  // Model: headings indexed N=0,S=1,L=2,O=3
  int    dr[4]   = '{-1, 1, 0, 0};
  int    dc[4]   = '{0, 0, 1, -1};
  int    rot[4]  = '{3, 2, 0, 1};
  int    vida[8] = '{0, 0, 0, 3, 6, 9, 0, 0};
  string m_modo = "PARADO";
  int    m_row, m_col, m_hd, m_vida, m_pulse, m_rl, m_rc, m_anom;
  bit    m_valid = 0;

  task automatic chk(input string nome, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s at %0t: got %0d expected %0d", nome, $time, act, exp);
    end
  endtask

  task automatic model_step();
    int nr, nc;
    m_pulse = 0;
    if (reset) begin
      m_valid = 1;
      m_modo = "PARADO";
      m_row = 0; m_col = 0; m_hd = 0; m_vida = 0; m_rl = 0; m_rc = 0; m_anom = 0;
    end else if (m_modo != "ANOMALIA") begin
      if (carregar) begin
        if (int'(linha_ini) >= 10 || int'(coluna_ini) >= 20) begin
          m_modo = "ANOMALIA"; m_anom = 1;
        end else begin
          m_modo = "ATIVO"; m_row = linha_ini; m_col = coluna_ini;
          m_hd = orient_ini; m_vida = 0;
        end
      end else if (m_modo == "ATIVO") begin
        nr = m_row + dr[m_hd];
        nc = m_col + dc[m_hd];
        if (recolher_entulho) begin
          if (vida[tipo_entulho] > 0) begin
            m_vida = vida[tipo_entulho] - 1;
            if (m_vida == 0) begin
              m_pulse = 1; m_rl = nr; m_rc = nc;
            end else m_modo = "REMOVENDO";
          end
        end else if (avancar) begin
          if (nr < 0 || nr >= 10 || nc < 0 || nc >= 20) begin
            m_modo = "ANOMALIA"; m_anom = 1;
          end else begin
            m_row = nr; m_col = nc;
          end
        end else if (girar) begin
          m_hd = rot[m_hd];
        end
      end else if (m_modo == "REMOVENDO") begin
        if (recolher_entulho) begin
          m_vida--;
          if (m_vida == 0) begin
            m_pulse = 1; m_rl = m_row + dr[m_hd]; m_rc = m_col + dc[m_hd];
            m_modo = "ATIVO";
          end
        end
      end
    end
  endtask

  always @(posedge clock) begin
    model_step();
    #1;
    if (m_valid) begin
      chk("linha", linha, m_row);
      chk("coluna", coluna, m_col);
      chk("orientacao", orientacao, m_hd);
      chk("entulho_vida", entulho_vida, m_vida);
      chk("entulho_removido", entulho_removido, m_pulse);
      chk("remov_linha", remov_linha, m_rl);
      chk("remov_coluna", remov_coluna, m_rc);
      chk("anomalia", anomalia, m_anom);
    end
  end

  task automatic passo(input logic rst, input logic c, input logic a,
                       input logic g, input logic r, input logic [2:0] t);
    @(negedge clock);
    reset = rst; carregar = c; avancar = a; girar = g;
    recolher_entulho = r; tipo_entulho = t;
    @(posedge clock);
    #2;
  endtask

  task automatic carga(input int l, input int c, input int o);
    linha_ini = 4'(l); coluna_ini = 5'(c); orient_ini = 2'(o);
    passo(0, 1, 0, 0, 0, 0);
  endtask

  initial begin
    int exp_hd[4] = '{3, 1, 2, 0};
    int exp_v6[6] = '{5, 4, 3, 2, 1, 0};

    passo(1, 0, 0, 0, 0, 0);
    passo(1, 0, 0, 0, 0, 0);
    chk("lit_reset_linha", linha, 0);
    chk("lit_reset_anom", anomalia, 0);
    passo(0, 0, 1, 1, 1, 5);  // ignored in PARADO
    chk("lit_parado_linha", linha, 0);

    carga(5, 10, 0);
    chk("lit_carga_linha", linha, 5);
    for (int i = 0; i < 3; i++) passo(0, 0, 1, 0, 0, 0);
    chk("lit_avanco_linha", linha, 2);
    chk("lit_avanco_coluna", coluna, 10);
    chk("lit_avanco_anom", anomalia, 0);

    for (int i = 0; i < 4; i++) begin
      passo(0, 0, 0, 1, 0, 0);
      chk("lit_giro", orientacao, 32'(exp_hd[i]));
    end

    for (int i = 0; i < 6; i++) begin
      passo(0, 0, 0, 0, 1, 4);
      chk("lit_medio_vida", entulho_vida, 32'(exp_v6[i]));
      chk("lit_medio_pulso", entulho_removido, (i == 5) ? 1 : 0);
    end
    chk("lit_remov_linha", remov_linha, 1);
    chk("lit_remov_coluna", remov_coluna, 10);
    passo(0, 0, 0, 0, 0, 0);
    chk("lit_pulso_baixo", entulho_removido, 0);

    for (int i = 0; i < 3; i++) passo(0, 0, 0, 0, 1, 5);
    chk("lit_pesado_vida", entulho_vida, 6);
    passo(0, 0, 1, 0, 0, 5);
    passo(0, 0, 0, 1, 0, 5);
    chk("lit_pesado_pausa", entulho_vida, 6);
    chk("lit_pesado_linha", linha, 2);
    chk("lit_pesado_orient", orientacao, 0);
    for (int i = 0; i < 6; i++) passo(0, 0, 0, 0, 1, 5);
    chk("lit_pesado_pulso", entulho_removido, 1);
    chk("lit_pesado_fim", entulho_vida, 0);

    for (int i = 0; i < 3; i++) passo(0, 0, 0, 0, 1, 3);
    passo(0, 0, 1, 0, 1, 1);  // non-debris code: removal ignored, advance also blocked
    chk("lit_livre_linha", linha, 2);
    passo(0, 0, 1, 0, 0, 0);
    passo(0, 0, 1, 0, 0, 0);
    chk("lit_topo_linha", linha, 0);
    passo(0, 0, 1, 0, 0, 0);
    chk("lit_borda_linha", linha, 0);
    chk("lit_borda_anom", anomalia, 1);
    carga(5, 10, 0);
    chk("lit_anom_carga", linha, 0);
    passo(1, 0, 0, 0, 0, 0);
    chk("lit_rst_anom", anomalia, 0);
    chk("lit_rst_remov", remov_coluna, 0);

    carga(12, 3, 0);
    chk("lit_carga_inval", anomalia, 1);
    passo(1, 0, 0, 0, 0, 0);

    carga(3, 4, 2);
    passo(0, 0, 1, 1, 0, 0);
    chk("lit_prio_coluna", coluna, 5);
    chk("lit_prio_orient", orientacao, 2);
    passo(0, 0, 0, 0, 1, 5);
    passo(0, 0, 0, 0, 1, 5);
    linha_ini = 4'd9; coluna_ini = 5'd0; orient_ini = 2'd1;
    passo(0, 1, 1, 0, 1, 5);  // load wins during removal
    chk("lit_carga_remov_vida", entulho_vida, 0);
    chk("lit_carga_remov_linha", linha, 9);
    passo(0, 0, 0, 0, 1, 5);
    passo(1, 0, 0, 0, 1, 5);
    chk("lit_rst_meio_vida", entulho_vida, 0);
    chk("lit_rst_meio_pulso", entulho_removido, 0);

    carga(9, 19, 1);
    passo(0, 0, 1, 0, 0, 0);
    chk("lit_borda_s", anomalia, 1);
    passo(1, 0, 0, 0, 0, 0);
    carga(4, 19, 2);
    passo(0, 0, 1, 0, 0, 0);
    chk("lit_borda_l", anomalia, 1);
    passo(1, 0, 0, 0, 0, 0);
    carga(4, 0, 3);
    passo(0, 0, 1, 0, 0, 0);
    chk("lit_borda_o", anomalia, 1);
    passo(0, 0, 0, 0, 0, 0);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
